// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage MULT/DIV sequencer owning HI/LO. The result is computed at the start edge, held pending,
// and committed after MULT_CYCLES/DIV_CYCLES busy cycles. stall freezes F/D while an MDU op waits.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic          commit_q, commit_d;

  // Arithmetic datapath, evaluated only for the operands present at the start edge.
  logic [63:0] prod_s, prod_u;
  logic        div_signed, div_zero;
  logic [31:0] div_a, div_b, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // One unsigned divider serves both DIV and DIVU via magnitude/sign fix-up.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    div_signed = (md_op == OP_DIV);
    div_zero   = (rt_val == 32'd0);
    div_a      = (div_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    div_b      = (div_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    if (div_zero) begin
      div_b = 32'd1;
    end
    q_mag = div_a / div_b;
    r_mag = div_a % div_b;
    quot  = (div_signed && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
    rem   = (div_signed && rs_val[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;

    case (state_q)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              commit_d             = 1'b1;
              cnt_d                = MULT_LOAD;
              state_d              = RUN;
            end
            OP_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              commit_d             = 1'b1;
              cnt_d                = MULT_LOAD;
              state_d              = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quot;
              // Divide by zero still occupies the unit but leaves HI/LO untouched.
              commit_d = !div_zero;
              cnt_d    = DIV_LOAD;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (commit_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    stall = d_is_md & (busy | (md_start & ~md_op[2]));
    hi    = hi_q;
    lo    = lo_q;
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a default instance and a fast instance (MULT 1 / DIV 3) share stimulus;
// expected busy length and HI/LO per op are queued at issue and checked when busy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start, fast_en, md_start_f;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        d_is_md;

  logic        busy0, stall0, busy1, stall1;
  logic [31:0] hi0, lo0, mdo0, hi1, lo1, mdo1;

  assign md_start_f = md_start & fast_en;

  mdu_ctrl dut0 (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
    .busy(busy0), .stall(stall0), .hi(hi0), .lo(lo0), .md_out(mdo0)
  );

  mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .md_start(md_start_f), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
    .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1), .md_out(mdo1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   run0 = 0;
  int   run1 = 0;
  int   scnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitors: measure each busy pulse and compare against the queued expectation.
  always @(negedge clk) begin
    if (busy0) begin
      run0++;
    end else if (run0 != 0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected: busy ran %0d cycles with no op expected", run0);
      end else begin
        e0 = q0.pop_front();
        chk({e0.tag, "_len0"}, 32'(run0), 32'(e0.len));
        chk({e0.tag, "_hi0"}, hi0, e0.hi);
        chk({e0.tag, "_lo0"}, lo0, e0.lo);
      end
      run0 = 0;
    end
  end

  always @(negedge clk) begin
    if (busy1) begin
      run1++;
    end else if (run1 != 0) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: busy ran %0d cycles with no op expected", run1);
      end else begin
        e1 = q1.pop_front();
        chk({e1.tag, "_len1"}, 32'(run1), 32'(e1.len));
        chk({e1.tag, "_hi1"}, hi1, e1.hi);
        chk({e1.tag, "_lo1"}, lo1, e1.lo);
      end
      run1 = 0;
    end
  end

  task automatic push(string tag, int l0, int l1, logic [31:0] h, logic [31:0] l);
    exp_t e;
    e.tag = tag;
    e.len = l0;
    e.hi  = h;
    e.lo  = l;
    q0.push_back(e);
    if (fast_en) begin
      e.len = l1;
      q1.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || busy1) && n < 40);
    if (busy0 || busy1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy0=%b busy1=%b after %0d cycles, required idle", tag, busy0, busy1, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd7;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    d_is_md  = 1'b0;
    fast_en  = 1'b1;
    #1;
    chk1("rst_busy0", busy0, 1'b0);
    chk1("rst_stall0", stall0, 1'b0);
    chk1("rst_busy1", busy1, 1'b0);
    chk1("rst_stall1", stall1, 1'b0);
    chk("rst_hi0", hi0, 32'd0);
    chk("rst_lo0", lo0, 32'd0);
    chk("rst_mdout0", mdo0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MULT -3 * 5 = -15
    push("mult", 5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_idle("mult");

    // MFLO / MFHI reads are combinational and change nothing.
    md_start = 1'b1;
    md_op    = 3'd7;
    #1;
    chk("mflo0", mdo0, 32'hFFFFFFF1);
    chk("mflo1", mdo1, 32'hFFFFFFF1);
    md_op = 3'd6;
    #1;
    chk("mfhi0", mdo0, 32'hFFFFFFFF);
    md_op = 3'd4;
    #1;
    chk("mdout_other", mdo0, 32'd0);
    md_op = 3'd7;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    chk1("mflo_no_busy", busy0, 1'b0);
    chk("mflo_keep_hi", hi0, 32'hFFFFFFFF);
    chk("mflo_keep_lo", lo0, 32'hFFFFFFF1);

    // MULTU 0xFFFFFFFF * 2
    push("multu", 5, 1, 32'h00000001, 32'hFFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu");

    // DIV -7 / 2 = -3 rem -1
    push("div", 10, 3, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");

    // MTHI / MTLO then DIVU by zero leaves them intact.
    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi0", hi0, 32'h12345678);
    chk1("mthi_no_busy", busy0, 1'b0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_lo0", lo0, 32'h9ABCDEF0);
    chk("mtlo_hi1", hi1, 32'h12345678);
    chk("mtlo_lo1", lo1, 32'h9ABCDEF0);
    push("divu0", 10, 3, 32'h12345678, 32'h9ABCDEF0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle("divu0");

    // DIV overflow 0x80000000 / -1
    push("divovf", 10, 3, 32'd0, 32'h80000000);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divovf");

    // Stall window: start cycle plus every busy cycle; mid-busy start is ignored.
    fast_en  = 1'b0;
    d_is_md  = 1'b1;
    md_start = 1'b1;
    md_op    = 3'd6;
    #1;
    chk1("stall_mfhi_idle", stall0, 1'b0);
    push("stallmult", 5, 0, 32'd0, 32'd12);
    md_op  = 3'd0;
    rs_val = 32'd3;
    rt_val = 32'd4;
    #1;
    scnt = 0;
    chk1("stall_start", stall0, 1'b1);
    if (stall0) scnt++;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        md_start = 1'b1;
        md_op    = 3'd0;
        rs_val   = 32'd7;
        rt_val   = 32'd7;
      end
      @(negedge clk);
      if (stall0) scnt++;
      if (i == 6) chk1("stall_drop", stall0, 1'b0);
      @(posedge clk);
      #1;
      if (i == 2) begin
        md_start = 1'b0;
        chk("midbusy_hi", hi0, 32'd0);
        chk("midbusy_lo", lo0, 32'h80000000);
      end
    end
    chk("stall_cycles", 32'(scnt), 32'd6);
    d_is_md = 1'b0;
    fast_en = 1'b1;

    // Reset during the 4th busy cycle of a DIV; the fast instance has already committed.
    e0.tag = "rst_abort";    e0.len = 4; e0.hi = 32'd0;        e0.lo = 32'd0;
    q0.push_back(e0);
    e1.tag = "rst_div_fast"; e1.len = 3; e1.hi = 32'hFFFFFFFF; e1.lo = 32'hFFFFFFFD;
    q1.push_back(e1);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    md_op = 3'd7;
    repeat (4) @(negedge clk);
    chk1("prerst_busy0", busy0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk1("async_busy0", busy0, 1'b0);
    chk("async_hi0", hi0, 32'd0);
    chk("async_lo0", lo0, 32'd0);
    chk("async_mdout0", mdo0, 32'd0);
    chk("async_hi1", hi1, 32'd0);
    chk("async_mdout1", mdo1, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    push("mult_after_rst", 5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_idle("mult_after_rst");

    repeat (3) @(posedge clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
